// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: decoded field bundle in, 32-bit instruction word out through a 2-entry FIFO.
// Optional macro IENC_PERF_COUNTERS_EN adds emitted/errored word counters.
module instr_encoder #(
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic [9:0]  funct,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [31:0] enc_count,
  output logic [31:0] err_count
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned EW   = ILEN + 1;
  localparam logic [1:0]  DEPTH = 2'(OUT_DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM_32 = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_32     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [ILEN-1:0] enc_instr;
  logic            enc_err;
  logic            i_imm_ok;
  logic            b_imm_ok;
  logic            j_imm_ok;
  logic            is_shift;

  // Upper immediate bits must be pure sign extension of the field the format keeps.
  assign i_imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_imm_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign j_imm_ok = (&imm[31:20]) | ~(|imm[31:20]);
  assign is_shift = (funct[9:7] == 3'b001) || (funct[9:7] == 3'b101);

  // Field packing per instruction format; an errored bundle encodes as all-zero.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    case (opcode)
      OP_32: begin
        enc_instr = {funct[9:3], rs2, rs1, funct[2:0], rd, opcode};
      end
      OP_IMM_32: begin
        if (is_shift) begin
          enc_instr = {funct[6:0], imm[4:0], rs1, funct[9:7], rd, opcode};
          enc_err   = (|imm[31:5]) || ((funct[9:7] == 3'b001) && (|funct[6:0]));
        end else begin
          enc_instr = {imm[11:0], rs1, funct[2:0], rd, opcode};
          enc_err   = !i_imm_ok || (|funct[9:3]);
        end
      end
      OP_JALR, OP_LOAD: begin
        enc_instr = {imm[11:0], rs1, funct[2:0], rd, opcode};
        enc_err   = !i_imm_ok || (|funct[9:3]);
      end
      OP_STORE: begin
        enc_instr = {imm[11:5], rs2, rs1, funct[2:0], imm[4:0], opcode};
        enc_err   = !i_imm_ok;
      end
      OP_BRANCH: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct[2:0], imm[4:1], imm[11], opcode};
        enc_err   = imm[0] || !b_imm_ok;
      end
      OP_JAL: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err   = imm[0] || !j_imm_ok;
      end
      OP_LUI, OP_AUIPC: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_err   = |imm[11:0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase
    if (enc_err) begin
      enc_instr = '0;
    end
  end

  // Two-slot FIFO: head_q drives the outputs directly, tail_q holds the second entry.
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          push;
  logic          pop;
  logic [EW-1:0] enc_entry;

  assign enc_entry = {enc_err, enc_instr};
  // A full buffer still accepts when the head is leaving this cycle.
  assign in_ready  = !full_q || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_instr = head_q[ILEN-1:0];
  assign out_err   = head_q[ILEN];

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = enc_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = enc_entry;
        end else if (push) begin
          tail_d  = enc_entry;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = enc_entry;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
    valid_d = (count_d != 2'd0);
    full_d  = (count_d == DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

`ifdef IENC_PERF_COUNTERS_EN
  // Counted on the output handshake so errored words are included once each.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (pop) begin
      enc_count <= enc_count + 32'd1;
      if (head_q[ILEN]) begin
        err_count <= err_count + 32'd1;
      end
    end
  end
`else
  assign enc_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table of encodings, backpressure, streaming and async reset,
// with a scoreboard queue fed on input handshakes and checked on output handshakes.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [9:0]  funct;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [31:0] enc_count;
  logic [31:0] err_count;

  always #5 clk = ~clk;

  instr_encoder #(.OUT_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t        vecs [NV];
  logic [32:0] sb [$];
  logic [32:0] cur_exp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          out_fires = 0;
  int          good [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [31:0] im, input logic [9:0] f,
                      input logic [31:0] ei, input logic ee);
    vecs[i].op = op; vecs[i].rs1 = a; vecs[i].rs2 = b; vecs[i].rd = d;
    vecs[i].imm = im; vecs[i].funct = f; vecs[i].exp_instr = ei; vecs[i].exp_err = ee;
  endtask

  task automatic drive(input int i);
    opcode  = vecs[i].op;
    rs1     = vecs[i].rs1;
    rs2     = vecs[i].rs2;
    rd      = vecs[i].rd;
    imm     = vecs[i].imm;
    funct   = vecs[i].funct;
    cur_exp = {vecs[i].exp_err, vecs[i].exp_instr};
    in_valid = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Scoreboard monitor, sampled mid-cycle when inputs and outputs are settled.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_fires++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got 0x%08h expected none", out_instr);
        end else begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e[31:0]);
          chk("out_err", 32'(out_err), 32'(e[32]));
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int n_err;
    int base;
    setv(0,  7'h13, 5'd0, 5'd0, 5'd1, 32'h0000_0005, 10'd0,          32'h0050_0093, 1'b0);
    setv(1,  7'h33, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 10'd0,          32'h0020_81B3, 1'b0);
    setv(2,  7'h13, 5'd6, 5'd0, 5'd5, 32'h0000_0003, 10'b1010100000, 32'h4033_5293, 1'b0);
    setv(3,  7'h37, 5'd5, 5'd7, 5'd2, 32'h1234_5000, 10'd0,          32'h1234_5137, 1'b0);
    setv(4,  7'h6F, 5'd0, 5'd0, 5'd1, 32'h0000_0008, 10'd0,          32'h0080_00EF, 1'b0);
    setv(5,  7'h23, 5'd1, 5'd2, 5'd0, 32'h0000_0008, 10'd2,          32'h0020_A423, 1'b0);
    setv(6,  7'h63, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 10'd0,          32'hFE20_8EE3, 1'b0);
    setv(7,  7'h03, 5'd6, 5'd0, 5'd5, 32'hFFFF_FFFF, 10'd2,          32'hFFF3_2283, 1'b0);
    setv(8,  7'h67, 5'd1, 5'd0, 5'd0, 32'h0000_0000, 10'd0,          32'h0000_8067, 1'b0);
    setv(9,  7'h17, 5'd0, 5'd0, 5'd4, 32'h0000_1000, 10'd0,          32'h0000_1217, 1'b0);
    setv(10, 7'h13, 5'd1, 5'd0, 5'd1, 32'h0000_07FF, 10'd0,          32'h7FF0_8093, 1'b0);
    setv(11, 7'h13, 5'd1, 5'd0, 5'd1, 32'hFFFF_F800, 10'd0,          32'h8000_8093, 1'b0);
    setv(12, 7'h13, 5'd1, 5'd0, 5'd1, 32'h0000_001F, 10'b0010000000, 32'h01F0_9093, 1'b0);
    setv(13, 7'h63, 5'd1, 5'd2, 5'd0, 32'h0000_0003, 10'd0,          32'h0000_0000, 1'b1);
    setv(14, 7'h13, 5'd1, 5'd0, 5'd1, 32'h0000_0800, 10'd0,          32'h0000_0000, 1'b1);
    setv(15, 7'h7F, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 10'd0,          32'h0000_0000, 1'b1);
    setv(16, 7'h13, 5'd1, 5'd0, 5'd1, 32'h0000_0001, 10'b0010000001, 32'h0000_0000, 1'b1);
    setv(17, 7'h13, 5'd1, 5'd0, 5'd1, 32'h0000_0020, 10'b1010000000, 32'h0000_0000, 1'b1);
    setv(18, 7'h37, 5'd0, 5'd0, 5'd2, 32'h0000_0001, 10'd0,          32'h0000_0000, 1'b1);
    setv(19, 7'h6F, 5'd0, 5'd0, 5'd1, 32'h0010_0000, 10'd0,          32'h0000_0000, 1'b1);
    setv(20, 7'h13, 5'd1, 5'd0, 5'd1, 32'h0000_0001, 10'b0000001000, 32'h0000_0000, 1'b1);
    n_err = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].exp_err) n_err++;
      else good.push_back(i);
    end

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cur_exp = '0;
    opcode = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0; funct = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_count", enc_count, 32'd0);
    chk("rst_err_count", err_count, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table: one bundle at a time, result must be valid the cycle after accept.
    for (int i = 0; i < NV; i++) begin
      drive(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("latency_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    chk("table_idle_valid", 32'(out_valid), 32'd0);
`ifdef IENC_PERF_COUNTERS_EN
    chk("table_enc_count", enc_count, 32'(NV));
    chk("table_err_count", err_count, 32'(n_err));
`else
    chk("table_enc_count", enc_count, 32'd0);
    chk("table_err_count", err_count, 32'd0);
`endif

    // Backpressure: two fill the buffer, the third enters on the first pop.
    out_ready = 1'b0;
    drive(0);
    @(posedge clk); #1;
    drive(1);
    @(posedge clk); #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    drive(2);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_instr", out_instr, vecs[0].exp_instr);
      chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_pop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_head_after_pop", out_instr, vecs[1].exp_instr);
    chk("bp_sb_depth", 32'(sb.size()), 32'd2);
    drain();

    // Streaming 16 words back to back from a fresh reset.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    base = out_fires;
    for (int k = 0; k < 16; k++) begin
      drive(good[k % good.size()]);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_rate", 32'(out_fires - base), 32'(k));
    end
    in_valid = 1'b0;
    drain();
    chk("stream_words", 32'(out_fires - base), 32'd16);
`ifdef IENC_PERF_COUNTERS_EN
    chk("stream_enc_count", enc_count, 32'd16);
    chk("stream_err_count", err_count, 32'd0);
`else
    chk("stream_enc_count", enc_count, 32'd0);
`endif

    // Async reset with two entries buffered.
    out_ready = 1'b0;
    drive(3);
    @(posedge clk); #1;
    drive(4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_enc_count", enc_count, 32'd0);
    chk("mid_rst_err_count", err_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_first", out_instr, vecs[5].exp_instr);
    drain();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    summary();
    $finish;
  end

endmodule
